// File: rtl/vec_mag_pkg.sv
// Shared constants, mode encoding and width helpers for the vector-magnitude engine.
// The coefficients are fractions over 2**COEFF_FRAC.
package vec_mag_pkg;

    localparam int COEFF_FRAC = 5;

    typedef enum logic {
        MODE_TWO_POINT = 1'b0,
        MODE_RADIUS    = 1'b1
    } vec_mode_e;

    // Width of a per-axis difference or magnitude: one extra bit, so -2^(W-1) - (2^(W-1)-1) fits.
    function automatic int mag_width(input int w);
        return w + 1;
    endfunction

    // Width of the weighted sum ALPHA*M + BETA*m. The coefficient sum is below 64, so 6 bits of growth always fit.
    function automatic int acc_width(input int w);
        return w + 7;
    endfunction

endpackage

// File: rtl/vec_mag_abs_diff.sv
// One axis of the front end: ST1 registers the signed difference (or the radius term),
// and ST2 registers its absolute value. Both stages advance together on en_i.
module vec_mag_abs_diff
    import vec_mag_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   abs_o
);

    logic signed [W:0] diff_d;
    logic signed [W:0] diff_q;
    logic        [W:0] abs_d;
    logic        [W:0] abs_q;

    always_comb begin
        if (vec_mode_e'(mode_i) == MODE_RADIUS) begin
            diff_d = $signed({b_i[W-1], b_i});
        end else begin
            diff_d = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});
        end
    end

    // The difference never reaches -2^W, so negating it in W+1 bits cannot overflow.
    assign abs_d = diff_q[W] ? $unsigned(-diff_q) : $unsigned(diff_q);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
            abs_q  <= '0;
        end else if (clr_i) begin
            diff_q <= '0;
            abs_q  <= '0;
        end else if (en_i) begin
            diff_q <= diff_d;
            abs_q  <= abs_d;
        end
    end

    assign abs_o = abs_q;

endmodule

// File: rtl/vec_mag_pipe.sv
// Four-stage AXI-Stream vector-magnitude engine: |v| ~ max(M, (A*M + B*m) >> 5).
// The whole pipeline advances on a single global enable, so bubbles travel with the data.
module vec_mag_pipe
    import vec_mag_pkg::*;
#(
    parameter int COORD_WIDTH = 8,
    parameter int ALPHA_NUM   = 31,
    parameter int BETA_NUM    = 13,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [4*COORD_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [4*COORD_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic                     core_reset_i,
    input  logic                     core_mode_i,
    output logic                     core_busy_o,
    output logic [CNT_WIDTH-1:0]     core_data_processed_cnt_o,
    output logic [15:0]              core_clamp_cnt_o
);

    localparam int W  = COORD_WIDTH;
    localparam int MW = mag_width(W);
    localparam int SW = acc_width(W);

    if (W < 4 || ALPHA_NUM < 1 || ALPHA_NUM > 32 || BETA_NUM < 0 || BETA_NUM > 32 ||
        ALPHA_NUM + BETA_NUM >= 64) begin : g_param_check
        $error("vec_mag_pipe: illegal parameter combination");
    end

    logic adv;
    logic in_fire;
    logic out_fire;

    assign adv           = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = adv && !core_reset_i;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;

    // ST1/ST2: one instance per axis.
    logic [MW-1:0] abs_x;
    logic [MW-1:0] abs_y;

    vec_mag_abs_diff #(.W(W)) u_axis_x (
        .clk    (aclk),
        .rst    (areset),
        .en_i   (adv),
        .clr_i  (core_reset_i),
        .mode_i (core_mode_i),
        .a_i    (s_axis_tdata[4*W-1 -: W]),
        .b_i    (s_axis_tdata[2*W-1 -: W]),
        .abs_o  (abs_x)
    );

    vec_mag_abs_diff #(.W(W)) u_axis_y (
        .clk    (aclk),
        .rst    (areset),
        .en_i   (adv),
        .clr_i  (core_reset_i),
        .mode_i (core_mode_i),
        .a_i    (s_axis_tdata[3*W-1 -: W]),
        .b_i    (s_axis_tdata[W-1 -: W]),
        .abs_o  (abs_y)
    );

    // ST3: major/minor split; a tie keeps |dx| as the major axis.
    logic [MW-1:0] mx_d;
    logic [MW-1:0] mn_d;
    logic [MW-1:0] mx_q;
    logic [MW-1:0] mn_q;

    assign mx_d = (abs_x >= abs_y) ? abs_x : abs_y;
    assign mn_d = (abs_x >= abs_y) ? abs_y : abs_x;

    // ST4: weighted sum, truncating shift, and the floor at M.
    logic [SW-1:0] sum_d;
    logic [MW-1:0] r_d;
    logic          floor_d;
    logic [MW-1:0] res_d;
    logic [MW-1:0] res_q;

    assign sum_d   = SW'(ALPHA_NUM) * SW'(mx_q) + SW'(BETA_NUM) * SW'(mn_q);
    assign r_d     = MW'(sum_d >> COEFF_FRAC);
    assign floor_d = r_d < mx_q;
    assign res_d   = floor_d ? mx_q : r_d;

    // Bit 0 is ST1, bit 3 is ST4; tlast is only ever set alongside a valid beat.
    logic [3:0]           vld_q;
    logic [3:0]           last_q;
    logic [CNT_WIDTH-1:0] proc_cnt_q;
    logic [15:0]          clamp_cnt_q;
    logic                 clamp_inc;

    assign clamp_inc = adv && vld_q[2] && floor_d && (clamp_cnt_q != 16'hFFFF);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_q       <= '0;
            last_q      <= '0;
            mx_q        <= '0;
            mn_q        <= '0;
            res_q       <= '0;
            proc_cnt_q  <= '0;
            clamp_cnt_q <= '0;
        end else if (core_reset_i) begin
            vld_q       <= '0;
            last_q      <= '0;
            mx_q        <= '0;
            mn_q        <= '0;
            res_q       <= '0;
            proc_cnt_q  <= '0;
            clamp_cnt_q <= '0;
        end else begin
            if (adv) begin
                vld_q  <= {vld_q[2:0], in_fire};
                last_q <= {last_q[2:0], in_fire && s_axis_tlast};
                mx_q   <= mx_d;
                mn_q   <= mn_d;
                res_q  <= res_d;
            end
            if (out_fire) begin
                proc_cnt_q <= proc_cnt_q + CNT_WIDTH'(1);
            end
            if (clamp_inc) begin
                clamp_cnt_q <= clamp_cnt_q + 16'd1;
            end
        end
    end

    assign m_axis_tdata              = {{(4*W-MW){1'b0}}, res_q};
    assign m_axis_tvalid             = vld_q[3];
    assign m_axis_tlast              = last_q[3];
    assign core_busy_o               = |vld_q;
    assign core_data_processed_cnt_o = proc_cnt_q;
    assign core_clamp_cnt_o          = clamp_cnt_q;

endmodule

// File: tb/tb_vec_mag_pipe.sv
// Directed bench for vec_mag_pipe (W = 8): latency, magnitude values, backpressure,
// synchronous flush and asynchronous reset, with hand-computed expectations.
module tb_vec_mag_pipe;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        core_reset_i;
    logic        core_mode_i;
    logic        core_busy_o;
    logic [31:0] core_data_processed_cnt_o;
    logic [15:0] core_clamp_cnt_o;

    int errors = 0;
    int checks = 0;

    vec_mag_pipe dut (
        .aclk                      (aclk),
        .areset                    (areset),
        .s_axis_tdata              (s_axis_tdata),
        .s_axis_tvalid             (s_axis_tvalid),
        .s_axis_tlast              (s_axis_tlast),
        .s_axis_tready             (s_axis_tready),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tready             (m_axis_tready),
        .core_reset_i              (core_reset_i),
        .core_mode_i               (core_mode_i),
        .core_busy_o               (core_busy_o),
        .core_data_processed_cnt_o (core_data_processed_cnt_o),
        .core_clamp_cnt_o          (core_clamp_cnt_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] pack(input int x1, input int y1, input int x2, input int y2);
        logic [31:0] v;
        v = {x1[7:0], y1[7:0], x2[7:0], y2[7:0]};
        return v;
    endfunction

    task automatic do_areset();
        @(negedge aclk);
        areset = 1'b1;
        #2;
        areset = 1'b0;
    endtask

    // One isolated beat with downstream always ready; checks exact 4-cycle latency.
    task automatic run_single(input logic [31:0] d, input logic mode, input logic last,
                              input logic [31:0] exp_d, input string name);
        @(negedge aclk);
        s_axis_tdata  = d;
        core_mode_i   = mode;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_valid: got %b expected 0", name, m_axis_tvalid);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: got %b expected 1", name, m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== exp_d) begin
            errors++;
            $display("FAIL %s_data: got %0d expected %0d", name, m_axis_tdata, exp_d);
        end
        checks++;
        if (m_axis_tlast !== last) begin
            errors++;
            $display("FAIL %s_last: got %b expected %b", name, m_axis_tlast, last);
        end
    endtask

    task automatic test_reset();
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        core_reset_i  = 1'b0;
        core_mode_i   = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%0d last=%b expected 0/0/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b expected 1", s_axis_tready);
        end
        checks++;
        if (core_busy_o !== 1'b0 || core_data_processed_cnt_o !== 32'd0 || core_clamp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b cnt=%0d clamp=%0d expected 0/0/0",
                     core_busy_o, core_data_processed_cnt_o, core_clamp_cnt_o);
        end
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_two_point();
        m_axis_tready = 1'b1;
        // M=4, m=3: s=163, r=5 -> 5
        run_single(pack(3, 4, 0, 0), 1'b0, 1'b1, 32'd5, "tp_small");
        // dx=dy=-255: s=11220, r=350 -> 350, needs all 9 bits
        run_single(pack(-128, -128, 127, 127), 1'b0, 1'b0, 32'd350, "tp_extreme");
    endtask

    task automatic test_radius();
        // M=10, m=0: s=310, r=9 < 10 -> floor to 10
        run_single(pack(99, 99, 10, 0), 1'b1, 1'b0, 32'd10, "radius_floor");
        checks++;
        if (core_clamp_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL radius_clamp_cnt: got %0d expected 1", core_clamp_cnt_o);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (core_data_processed_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL processed_after_singles: got %0d expected 3", core_data_processed_cnt_o);
        end
    endtask

    task automatic test_flush();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            s_axis_tdata  = pack(0, 0, 10, 0);
            core_mode_i   = 1'b1;
            s_axis_tvalid = 1'b1;
        end
        @(negedge aclk);
        core_reset_i = 1'b1;
        #1;
        checks++;
        if (core_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before: got %b expected 1", core_busy_o);
        end
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL flush_tready_low: got %b expected 0", s_axis_tready);
        end
        @(negedge aclk);
        core_reset_i  = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if (core_busy_o !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cleared: got busy=%b valid=%b expected 0/0", core_busy_o, m_axis_tvalid);
        end
        checks++;
        if (core_data_processed_cnt_o !== 32'd0 || core_clamp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL flush_counters: got cnt=%0d clamp=%0d expected 0/0",
                     core_data_processed_cnt_o, core_clamp_cnt_o);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL flush_tready_back: got %b expected 1", s_axis_tready);
        end
        repeat (5) @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || core_clamp_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL flush_no_ghost: got valid=%b clamp=%0d expected 0/0", m_axis_tvalid, core_clamp_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vecs  [8];
        logic        modes [8];
        logic [31:0] exp_d [8];
        logic        exp_l [8];
        logic [31:0] held_d;
        logic        held_l;
        logic        held_v;
        int          prod;
        int          cons;
        int          cyc;

        vecs[0] = pack(0, 0, 10, 0);     modes[0] = 1'b1; exp_d[0] = 32'd10;  exp_l[0] = 1'b0;
        vecs[1] = pack(0, 0, 3, 4);      modes[1] = 1'b1; exp_d[1] = 32'd5;   exp_l[1] = 1'b0;
        vecs[2] = pack(0, 0, 0, 0);      modes[2] = 1'b1; exp_d[2] = 32'd0;   exp_l[2] = 1'b0;
        vecs[3] = pack(0, 0, 5, -12);    modes[3] = 1'b0; exp_d[3] = 32'd13;  exp_l[3] = 1'b1;
        vecs[4] = pack(0, 0, 7, 7);      modes[4] = 1'b1; exp_d[4] = 32'd9;   exp_l[4] = 1'b0;
        vecs[5] = pack(55, -3, 100, -1); modes[5] = 1'b1; exp_d[5] = 32'd100; exp_l[5] = 1'b0;
        vecs[6] = pack(0, 0, -128, 0);   modes[6] = 1'b1; exp_d[6] = 32'd128; exp_l[6] = 1'b0;
        vecs[7] = pack(0, 0, 1, 1);      modes[7] = 1'b1; exp_d[7] = 32'd1;   exp_l[7] = 1'b1;

        do_areset();
        prod   = 0;
        cons   = 0;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        for (cyc = 0; cyc < 200 && cons < 8; cyc++) begin
            @(negedge aclk);
            m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (prod < 8 && cyc != 2) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = vecs[prod];
                core_mode_i   = modes[prod];
                s_axis_tlast  = exp_l[prod];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            #1;
            if (held_v) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
                    errors++;
                    $display("FAIL stall_stable cyc %0d: got valid=%b data=%0d last=%b expected 1/%0d/%b",
                             cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_d, held_l);
                end
            end
            checks++;
            if (s_axis_tready !== (!m_axis_tvalid || m_axis_tready)) begin
                errors++;
                $display("FAIL tready_tracks_adv cyc %0d: got %b expected %b",
                         cyc, s_axis_tready, (!m_axis_tvalid || m_axis_tready));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (m_axis_tdata !== exp_d[cons] || m_axis_tlast !== exp_l[cons]) begin
                    errors++;
                    $display("FAIL stream_beat %0d: got data=%0d last=%b expected %0d/%b",
                             cons, m_axis_tdata, m_axis_tlast, exp_d[cons], exp_l[cons]);
                end
                cons++;
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held_d = m_axis_tdata;
            held_l = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) prod++;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (cons != 8) begin
            errors++;
            $display("FAIL stream_timeout: got %0d beats expected 8", cons);
        end
        @(negedge aclk);
        #1;
        checks++;
        if (core_busy_o !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: got busy=%b valid=%b expected 0/0", core_busy_o, m_axis_tvalid);
        end
        checks++;
        if (core_data_processed_cnt_o !== 32'd8) begin
            errors++;
            $display("FAIL stream_processed: got %0d expected 8", core_data_processed_cnt_o);
        end
        checks++;
        if (core_clamp_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL stream_clamp: got %0d expected 3", core_clamp_cnt_o);
        end
    endtask

    task automatic test_areset_stall();
        m_axis_tready = 1'b0;
        @(negedge aclk);
        s_axis_tdata  = pack(3, 4, 0, 0);
        core_mode_i   = 1'b0;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 10 && m_axis_tvalid !== 1'b1; i++) @(negedge aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd5 || m_axis_tlast !== 1'b1) begin
            errors++;
            $display("FAIL stall_arrive: got valid=%b data=%0d last=%b expected 1/5/1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_tready: got %b expected 0", s_axis_tready);
        end
        #1;
        areset = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL async_clear_out: got valid=%b data=%0d last=%b expected 0/0/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (core_busy_o !== 1'b0 || core_data_processed_cnt_o !== 32'd0 ||
            core_clamp_cnt_o !== 16'd0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL async_clear_status: got busy=%b cnt=%0d clamp=%0d tready=%b expected 0/0/0/1",
                     core_busy_o, core_data_processed_cnt_o, core_clamp_cnt_o, s_axis_tready);
        end
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_point();
        test_radius();
        test_flush();
        test_back_to_back();
        test_areset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
